evtpack: RTL and testbench

Event framer placed directly downstream of the ALPIDE control-port readout sequencer. Accepts the 24-bit hit words and end-of-event marker that the sequencer writes. Buffers them in a small FIFO whose full flag throttles the sequencer. Emits 32-bit framed words (header, data, trailer) over a valid/ready stream toward the host-link FIFO.

---
 rtl/evtpack_if.sv | 21 ++
 rtl/evtpack.sv | 182 ++++++++++++++++++
 tb/tb_evtpack.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/evtpack_if.sv
// Event-input and framed-output stream bundle for evtpack.
// The slave modport is the framer's view; the master modport is the sequencer/host view.
interface evtpack_if;
   logic [23:0] evt_data_i;
   logic        evt_we_i;
   logic        evt_done_i;
   logic        evt_full_o;
   logic [31:0] out_data_o;
   logic        out_valid_o;
   logic        out_ready_i;

   modport slave (
      input  evt_data_i, evt_we_i, evt_done_i, out_ready_i,
      output evt_full_o, out_data_o, out_valid_o
   );

   modport master (
      output evt_data_i, evt_we_i, evt_done_i, out_ready_i,
      input  evt_full_o, out_data_o, out_valid_o
   );
endinterface

// File: rtl/evtpack.sv
// evtpack: buffers 24-bit hit words and frames them as header/data/trailer 32-bit words on a valid/ready stream.
// Defining EVTPACK_TIMESTAMP_EN inserts a latched free-running cycle count word after each header.
module evtpack #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        reg_we_i,
   input  logic [7:0]  reg_addr_i,
   input  logic [15:0] reg_data_i,
   output logic [15:0] reg_data_o,
   evtpack_if.slave    bus
);
   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

   typedef logic [DEPTH_LOG2-1:0] ptr_t;
   typedef logic [DEPTH_LOG2:0]   cnt_t;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_DATA = 3'd2,
      ST_TRL  = 3'd3
`ifdef EVTPACK_TIMESTAMP_EN
      , ST_TS = 3'd4
`endif
   } state_t;

   state_t      state_q, state_d;
   logic        enable_q, enable_d;
   logic [24:0] mem_q [DEPTH];
   ptr_t        wr_ptr_q, wr_ptr_d;
   ptr_t        rd_ptr_q, rd_ptr_d;
   cnt_t        count_q, count_d;
   logic [15:0] evt_id_q, evt_id_d;
   logic [15:0] ovf_cnt_q, ovf_cnt_d;
   logic        ovf_flag_q, ovf_flag_d;
   logic        trl_ovf_q, trl_ovf_d;
   logic [23:0] nwords_q, nwords_d;

   logic        soft_rst, clr;
   logic        full, empty, push, drop, pop, trl_acc;
   logic [24:0] head;
   logic        out_valid;
   logic [31:0] out_data;
   logic [15:0] status;

   assign soft_rst = reg_we_i && (reg_addr_i == 8'h02) && (reg_data_i == 16'h0000);
   assign clr      = rst_i || soft_rst;
   assign full     = (count_q == FULL_CNT);
   assign empty    = (count_q == '0);
   // Full is judged on the registered count, so a same-cycle pop never rescues a push.
   assign push     = bus.evt_we_i && enable_q && !full;
   assign drop     = bus.evt_we_i && !push;
   assign head     = mem_q[rd_ptr_q];
   assign pop      = (state_q == ST_DATA) && !empty && bus.out_ready_i;
   assign trl_acc  = (state_q == ST_TRL) && bus.out_ready_i;

   assign bus.evt_full_o  = full || !enable_q;
   assign bus.out_valid_o = out_valid;
   assign bus.out_data_o  = out_data;

`ifdef EVTPACK_TIMESTAMP_EN
   logic [31:0] ts_cnt_q, ts_lat_q;

   always_ff @(posedge clk_i) begin
      if (clr) begin
         ts_cnt_q <= '0;
         ts_lat_q <= '0;
      end else begin
         ts_cnt_q <= ts_cnt_q + 32'd1;
         if (state_q == ST_IDLE && state_d == ST_HDR) ts_lat_q <= ts_cnt_q;
      end
   end
`endif

   always_comb begin
      state_d   = state_q;
      out_valid = 1'b0;
      out_data  = 32'h0;
      case (state_q)
         ST_IDLE: begin
            if (enable_q && !empty) state_d = ST_HDR;
         end
         ST_HDR: begin
            out_valid = 1'b1;
            out_data  = {4'hA, 12'h000, evt_id_q};
`ifdef EVTPACK_TIMESTAMP_EN
            if (bus.out_ready_i) state_d = ST_TS;
`else
            if (bus.out_ready_i) state_d = ST_DATA;
`endif
         end
`ifdef EVTPACK_TIMESTAMP_EN
         ST_TS: begin
            out_valid = 1'b1;
            out_data  = ts_lat_q;
            if (bus.out_ready_i) state_d = ST_DATA;
         end
`endif
         ST_DATA: begin
            out_valid = !empty;
            out_data  = empty ? 32'h0 : {8'h00, head[23:0]};
            if (pop && head[24]) state_d = ST_TRL;
         end
         ST_TRL: begin
            out_valid = 1'b1;
            out_data  = {4'hE, 3'b000, trl_ovf_q, nwords_q};
            if (bus.out_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      enable_d = enable_q;
      if (reg_we_i && reg_addr_i == 8'h01) enable_d = reg_data_i[0];

      wr_ptr_d = push ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop)      count_d = count_q + cnt_t'(1);
      else if (pop && !push) count_d = count_q - cnt_t'(1);

      evt_id_d = trl_acc ? evt_id_q + 16'd1 : evt_id_q;
      nwords_d = nwords_q;
      if (trl_acc)  nwords_d = '0;
      else if (pop) nwords_d = nwords_q + 24'd1;

      // Trailer overflow bit is frozen when the done word leaves, keeping the trailer stable while held.
      ovf_flag_d = (trl_acc ? 1'b0 : ovf_flag_q) | drop;
      trl_ovf_d  = (pop && head[24]) ? ovf_flag_q : trl_ovf_q;
      ovf_cnt_d  = (drop && ovf_cnt_q != 16'hFFFF) ? ovf_cnt_q + 16'd1 : ovf_cnt_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) enable_q <= 1'b0;
      else       enable_q <= enable_d;
   end

   always_ff @(posedge clk_i) begin
      if (clr) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         evt_id_q   <= '0;
         ovf_cnt_q  <= '0;
         ovf_flag_q <= 1'b0;
         trl_ovf_q  <= 1'b0;
         nwords_q   <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         evt_id_q   <= evt_id_d;
         ovf_cnt_q  <= ovf_cnt_d;
         ovf_flag_q <= ovf_flag_d;
         trl_ovf_q  <= trl_ovf_d;
         nwords_q   <= nwords_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= {bus.evt_done_i, bus.evt_data_i};
   end

   assign status = {10'b0, 3'(state_q), enable_q, empty, full};

   always_comb begin
      reg_data_o = 16'hF001;
      case (reg_addr_i)
         8'h00, 8'h02: reg_data_o = status;
         8'h01:        reg_data_o = {15'b0, enable_q};
         8'h03:        reg_data_o = evt_id_q;
         8'h04:        reg_data_o = ovf_cnt_q;
         default:      reg_data_o = 16'hF001;
      endcase
   end
endmodule

// File: tb/tb_evtpack.sv
// Directed bench for evtpack (DEPTH_LOG2=2): scoreboard of expected framed words plus register checks.
module tb_evtpack;
   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        reg_we_i;
   logic [7:0]  reg_addr_i;
   logic [15:0] reg_data_i;
   logic [15:0] reg_data_o;

   evtpack_if bus ();

   evtpack #(.DEPTH_LOG2(2)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .reg_we_i   (reg_we_i),
      .reg_addr_i (reg_addr_i),
      .reg_data_i (reg_data_i),
      .reg_data_o (reg_data_o),
      .bus        (bus)
   );

   always #5 clk_i = ~clk_i;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] exp_q[$];
   bit          stab_en   = 1'b0;
   bit          prev_hold = 1'b0;
   logic [31:0] prev_data = 32'h0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic reg_wr(input logic [7:0] a, input logic [15:0] d);
      reg_we_i   = 1'b1;
      reg_addr_i = a;
      reg_data_i = d;
      tick();
      reg_we_i   = 1'b0;
   endtask

   task automatic rd_chk(input logic [7:0] a, input logic [15:0] e, input string tag);
      reg_addr_i = a;
      #1;
      check(tag, 32'(reg_data_o), 32'(e));
   endtask

   task automatic evt_wr(input logic [23:0] d, input logic done);
      bus.evt_data_i = d;
      bus.evt_done_i = done;
      bus.evt_we_i   = 1'b1;
      tick();
      bus.evt_we_i   = 1'b0;
      bus.evt_done_i = 1'b0;
   endtask

   task automatic drain(input string tag, input bit toggle);
      int budget = 200;
      while (exp_q.size() != 0 && budget > 0) begin
         if (toggle) bus.out_ready_i = ~bus.out_ready_i;
         tick();
         budget--;
      end
      check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
      tick();
   endtask

   // Output monitor: inputs only change just after posedge, so negedge sees the values the next edge uses.
   always @(negedge clk_i) begin
      if (stab_en && prev_hold) begin
         check("hold_valid", 32'(bus.out_valid_o), 32'd1);
         check("hold_data", bus.out_data_o, prev_data);
      end
      prev_hold = stab_en && bus.out_valid_o && !bus.out_ready_i;
      prev_data = bus.out_data_o;
      if (bus.out_valid_o && bus.out_ready_i) begin
         check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) check("stream_word", bus.out_data_o, exp_q.pop_front());
      end
   end

   initial begin
      rst_i = 1'b1;
      reg_we_i = 1'b0;
      reg_addr_i = 8'h00;
      reg_data_i = 16'h0;
      bus.evt_data_i = 24'h0;
      bus.evt_we_i = 1'b0;
      bus.evt_done_i = 1'b0;
      bus.out_ready_i = 1'b0;
      repeat (3) tick();

      check("rst_valid", 32'(bus.out_valid_o), 32'd0);
      check("rst_data", bus.out_data_o, 32'h0);
      check("rst_full", 32'(bus.evt_full_o), 32'd1);
      rd_chk(8'h00, 16'h0002, "rst_status");
      rd_chk(8'h03, 16'h0000, "rst_evtid");
      rd_chk(8'h04, 16'h0000, "rst_ovfcnt");
      rst_i = 1'b0;
      tick();

      reg_wr(8'h01, 16'h0001);
      check("en_full", 32'(bus.evt_full_o), 32'd0);
      rd_chk(8'h00, 16'h0006, "en_status");
      rd_chk(8'h01, 16'h0001, "en_ctrl");

      // Single event with ready held high, including first-word latency.
      bus.out_ready_i = 1'b1;
      stab_en = 1'b1;
      exp_q.push_back(32'hA000_0000);
      exp_q.push_back(32'h0012_3456);
      exp_q.push_back(32'h00AB_CDEF);
      exp_q.push_back(32'hE000_0002);
      bus.evt_data_i = 24'h123456;
      bus.evt_done_i = 1'b0;
      bus.evt_we_i   = 1'b1;
      tick();
      check("lat_valid_n", 32'(bus.out_valid_o), 32'd0);
      rd_chk(8'h00, 16'h0004, "lat_status_n");
      bus.evt_data_i = 24'hABCDEF;
      bus.evt_done_i = 1'b1;
      tick();
      bus.evt_we_i   = 1'b0;
      bus.evt_done_i = 1'b0;
      check("lat_valid_n1", 32'(bus.out_valid_o), 32'd1);
      check("lat_hdr_n1", bus.out_data_o, 32'hA000_0000);
      drain("single", 1'b0);
      rd_chk(8'h03, 16'h0001, "evtid_after_single");

      // Same event with ready toggling every cycle.
      bus.out_ready_i = 1'b0;
      exp_q.push_back(32'hA000_0001);
      exp_q.push_back(32'h0012_3456);
      exp_q.push_back(32'h00AB_CDEF);
      exp_q.push_back(32'hE000_0002);
      evt_wr(24'h123456, 1'b0);
      evt_wr(24'hABCDEF, 1'b1);
      drain("backpressure", 1'b1);
      rd_chk(8'h03, 16'h0002, "evtid_after_bp");
      bus.out_ready_i = 1'b0;
      tick();

      // Disabled writes are dropped and counted.
      reg_wr(8'h01, 16'h0000);
      check("dis_full", 32'(bus.evt_full_o), 32'd1);
      evt_wr(24'h111111, 1'b0);
      evt_wr(24'h222222, 1'b1);
      rd_chk(8'h04, 16'h0002, "dis_ovfcnt");
      rd_chk(8'h00, 16'h0002, "dis_status");
      rd_chk(8'h05, 16'hF001, "bad_addr");
      reg_wr(8'h02, 16'h0000);
      rd_chk(8'h04, 16'h0000, "srst_idle_ovfcnt");
      rd_chk(8'h03, 16'h0000, "srst_idle_evtid");
      rd_chk(8'h00, 16'h0002, "srst_idle_status");
      check("srst_idle_full", 32'(bus.evt_full_o), 32'd1);

      // Overflow with a 4-entry FIFO and ready held low.
      reg_wr(8'h01, 16'h0001);
      exp_q.push_back(32'hA000_0000);
      for (int i = 1; i <= 4; i++) exp_q.push_back(32'(i));
      for (int i = 1; i <= 6; i++) begin
         evt_wr(24'(i), i == 6);
         check($sformatf("ovf_full_w%0d", i), 32'(bus.evt_full_o), 32'(i >= 4));
      end
      rd_chk(8'h04, 16'h0002, "ovf_cnt");
      rd_chk(8'h00, 16'h000D, "ovf_status");
      bus.out_ready_i = 1'b1;
      drain("ovf_part", 1'b0);
      check("ovf_wait_valid", 32'(bus.out_valid_o), 32'd0);
      check("ovf_wait_full", 32'(bus.evt_full_o), 32'd0);
      rd_chk(8'h00, 16'h0016, "ovf_wait_status");
      exp_q.push_back(32'h0000_0777);
      exp_q.push_back(32'hE100_0005);
      evt_wr(24'h000777, 1'b1);
      drain("ovf_recover", 1'b0);
      rd_chk(8'h03, 16'h0001, "evtid_after_ovf");
      bus.out_ready_i = 1'b0;
      tick();

      // Soft reset in the middle of the data phase.
      exp_q.push_back(32'hA000_0001);
      exp_q.push_back(32'h0000_00A1);
      evt_wr(24'h0000A1, 1'b0);
      evt_wr(24'h0000A2, 1'b0);
      evt_wr(24'h0000A3, 1'b0);
      bus.out_ready_i = 1'b1;
      tick();
      tick();
      bus.out_ready_i = 1'b0;
      check("mid_sb_empty", 32'(exp_q.size()), 32'd0);
      check("mid_valid", 32'(bus.out_valid_o), 32'd1);
      check("mid_data", bus.out_data_o, 32'h0000_00A2);
      stab_en = 1'b0;
      reg_wr(8'h02, 16'h0000);
      check("srst_valid", 32'(bus.out_valid_o), 32'd0);
      check("srst_full", 32'(bus.evt_full_o), 32'd0);
      rd_chk(8'h00, 16'h0006, "srst_status");
      rd_chk(8'h03, 16'h0000, "srst_evtid");
      stab_en = 1'b1;
      bus.out_ready_i = 1'b1;
      exp_q.push_back(32'hA000_0000);
      exp_q.push_back(32'h0000_00B1);
      exp_q.push_back(32'hE000_0001);
      evt_wr(24'h0000B1, 1'b1);
      drain("post_srst", 1'b0);
      rd_chk(8'h03, 16'h0001, "evtid_final");
      rd_chk(8'h00, 16'h0006, "status_final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
